// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, counter sizing, divide-by-zero fill.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Quotient bit pattern reported on divide by zero (all ones)
    localparam logic DZ_FILL = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/div8u_seq_if.sv
// Request/result bundle of the sequential divider.
interface div8u_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             START;
    logic             SGN;
    logic [WIDTH-1:0] DVD;
    logic [WIDTH-1:0] DVS;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] QUO;
    logic [WIDTH-1:0] REM;
    logic             DZ;

    modport master (output START, SGN, DVD, DVS, input BUSY, DONE, QUO, REM, DZ);
    modport slave  (input START, SGN, DVD, DVS, output BUSY, DONE, QUO, REM, DZ);
endinterface

// File: rtl/div_addsub.sv
// N-bit add/subtract slice; con=1 subtracts (a-b), bout_c is carry-out on add, borrow-out on subtract.
module div_addsub #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         con,
    output logic [N-1:0] sum_c,
    output logic         bout_c
);
    logic carry;

    assign {carry, sum_c} = {1'b0, a} + {1'b0, b ^ {N{con}}} + (N+1)'(con);
    assign bout_c = carry ^ con;
endmodule

// File: rtl/div8u_seq.sv
// Sequential restoring divider, one trial subtract per clock.
// Optional two's complement mode under macro DIV_SIGNED_EN.
module div8u_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic        CK,
    input logic        RSTN,
    div8u_seq_if.slave bus
);
    localparam int unsigned CW = clog2(WIDTH);

    state_t           state, state_nxt;
    logic             accept_c, last_c;
    logic [WIDTH-1:0] d, r, q, dvs;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   p_c, t_c;
    logic             borrow_c;
    logic [WIDTH-1:0] r_nxt_c, q_nxt_c;
    logic [WIDTH-1:0] dvd_mag_c, dvs_mag_c, quo_fix_c, rem_fix_c;
    logic             busy, done, dz;
    logic [WIDTH-1:0] quo, rem;

    assign last_c = (count == '0);

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Accept is possible in IDLE and on the DONE cycle; zero divisor skips straight to FIN
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        case (state)
            ST_IDLE, ST_FIN: begin
                state_nxt = ST_IDLE;
                if (bus.START) begin
                    accept_c  = 1'b1;
                    state_nxt = (bus.DVS == '0) ? ST_FIN : ST_CALC;
                end
            end
            ST_CALC: if (last_c) state_nxt = ST_FIN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign p_c = {r, d[WIDTH-1]};

    div_addsub #(.N(WIDTH + 1)) u_addsub (
        .a      (p_c),
        .b      ({1'b0, dvs}),
        .con    (1'b1),
        .sum_c  (t_c),
        .bout_c (borrow_c)
    );

    assign r_nxt_c = borrow_c ? p_c[WIDTH-1:0] : t_c[WIDTH-1:0];
    assign q_nxt_c = {q[WIDTH-2:0], ~borrow_c};

    // Remainder stays below the divisor, so the slice MSBs carry no information
    wire unused_msb = t_c[WIDTH] ^ p_c[WIDTH];

`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;
    logic dvd_neg_c, dvs_neg_c;

    assign dvd_neg_c = bus.SGN & bus.DVD[WIDTH-1];
    assign dvs_neg_c = bus.SGN & bus.DVS[WIDTH-1];
    assign dvd_mag_c = dvd_neg_c ? WIDTH'(-bus.DVD) : bus.DVD;
    assign dvs_mag_c = dvs_neg_c ? WIDTH'(-bus.DVS) : bus.DVS;

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept_c) begin
            neg_q <= dvd_neg_c ^ dvs_neg_c;
            neg_r <= dvd_neg_c;
        end
    end

    assign quo_fix_c = neg_q ? WIDTH'(-q_nxt_c) : q_nxt_c;
    assign rem_fix_c = neg_r ? WIDTH'(-r_nxt_c) : r_nxt_c;
`else
    wire unused_sgn = bus.SGN;

    assign dvd_mag_c = bus.DVD;
    assign dvs_mag_c = bus.DVS;
    assign quo_fix_c = q_nxt_c;
    assign rem_fix_c = r_nxt_c;
`endif

    // Datapath, counter and registered result/status
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            d     <= '0;
            r     <= '0;
            q     <= '0;
            dvs   <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dz    <= 1'b0;
            quo   <= '0;
            rem   <= '0;
        end else begin
            if (accept_c) begin
                d     <= dvd_mag_c;
                dvs   <= dvs_mag_c;
                r     <= '0;
                q     <= '0;
                count <= CW'(WIDTH - 1);
            end else if (state == ST_CALC) begin
                d     <= {d[WIDTH-2:0], 1'b0};
                r     <= r_nxt_c;
                q     <= q_nxt_c;
                count <= count - CW'(1);
            end

            busy <= (state_nxt == ST_CALC);
            done <= (state_nxt == ST_FIN);

            if (accept_c && (bus.DVS == '0)) begin
                quo <= {WIDTH{DZ_FILL}};
                rem <= bus.DVD;
                dz  <= 1'b1;
            end else if ((state == ST_CALC) && last_c) begin
                quo <= quo_fix_c;
                rem <= rem_fix_c;
                dz  <= 1'b0;
            end
        end
    end

    assign bus.BUSY = busy;
    assign bus.DONE = done;
    assign bus.QUO  = quo;
    assign bus.REM  = rem;
    assign bus.DZ   = dz;

endmodule
